// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue/control stage and the ALU it feeds.
//  - data / register-file geometry
//  - opcode constants (the ALU decodes the same ADD..AND values)
//  - instruction field bit positions
//  - issue FSM state encoding
package alu_issue_ctrl_pkg;

  localparam int N    = 16;
  localparam int NREG = 8;
  localparam int RW   = 3;  // register index width

  // ALU opcodes, passed through unchanged on alu_op
  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_SLT = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0011;
  localparam logic [3:0] OP_SLR = 4'b0100;
  localparam logic [3:0] OP_AND = 4'b0101;
  // Opcodes handled locally by the issue stage
  localparam logic [3:0] OP_MV  = 4'b0110;
  localparam logic [3:0] OP_MVI = 4'b0111;

  // Instruction fields: [15:12] opcode, [11:9] rd, [8:6] rs1, [5:3] rs2, [2:0] unused
  localparam int OPC_HI = 15;
  localparam int OPC_LO = 12;
  localparam int RD_HI  = 11;
  localparam int RD_LO  = 9;
  localparam int RS1_HI = 8;
  localparam int RS1_LO = 6;
  localparam int RS2_HI = 5;
  localparam int RS2_LO = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_IMM    = 3'd3,
    ST_WB     = 3'd4
  } state_t;

  // Opcodes 0000..0101 go to the ALU
  function automatic logic is_alu_op(input logic [3:0] op);
    return (op <= OP_AND);
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_regfile8x16.sv
// 8 x 16 register file for the ALU issue stage.
//  clk, rst_n : clock, asynchronous active-low clear of every entry
//  we/wa/wd   : single synchronous write port
//  ra1/rd1    : async read port (rs1)
//  ra2/rd2    : async read port (rs2)
//  rad/rdd    : async debug read port
module regfile8x16
  import alu_issue_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [RW-1:0] wa,
  input  logic [N-1:0]  wd,
  input  logic [RW-1:0] ra1,
  input  logic [RW-1:0] ra2,
  input  logic [RW-1:0] rad,
  output logic [N-1:0]  rd1,
  output logic [N-1:0]  rd2,
  output logic [N-1:0]  rdd
);

  logic [N-1:0] mem [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (we) begin
      mem[wa] <= wd;
    end
  end

  assign rd1 = mem[ra1];
  assign rd2 = mem[ra2];
  assign rdd = mem[rad];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/control stage in front of the 16-bit ALU. One instruction in flight.
//  Clock, Resetn            : rising-edge clock, asynchronous active-low reset
//  instr_valid/instr_data/
//  instr_ready              : instruction (or MVI immediate) word input
//  alu_a, alu_b, alu_op,
//  alu_addsub               : registered ALU drive, held outside EXEC
//  alu_result               : combinational ALU result, written back in WB
//  done                     : high for the single WB cycle (write commits at its end)
//  illegal                  : one-cycle pulse after an undefined opcode is dropped
//  dbg_sel/dbg_data         : asynchronous register-file peek
//  dbg_state                : current FSM state
//
// Handshake: a word transfers on a rising edge where instr_valid and instr_ready
// are both high. instr_ready depends only on state (IDLE or IMM); the source must
// hold instr_data stable while instr_valid is high and instr_ready is low.
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
(
  input  logic          Clock,
  input  logic          Resetn,
  input  logic          instr_valid,
  input  logic [N-1:0]  instr_data,
  output logic          instr_ready,
  output logic [N-1:0]  alu_a,
  output logic [N-1:0]  alu_b,
  output logic [3:0]    alu_op,
  output logic          alu_addsub,
  input  logic [N-1:0]  alu_result,
  output logic          done,
  output logic          illegal,
  input  logic [RW-1:0] dbg_sel,
  output logic [N-1:0]  dbg_data,
  output state_t        dbg_state
);

  state_t state, state_nxt;

  // Bits [2:0] of the instruction carry nothing, so IR keeps only [15:3]
  logic [N-1:3] ir;
  logic [N-1:0] imm;
  logic         illegal_q;

  logic [3:0]    opcode;
  logic [RW-1:0] rd, rs1, rs2;
  logic [N-1:0]  rs1_data, rs2_data, wb_data;
  logic          accept, wb_en;

  assign opcode = ir[OPC_HI:OPC_LO];
  assign rd     = ir[RD_HI:RD_LO];
  assign rs1    = ir[RS1_HI:RS1_LO];
  assign rs2    = ir[RS2_HI:RS2_LO];

  assign instr_ready = (state == ST_IDLE) || (state == ST_IMM);
  assign accept      = instr_valid && instr_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (accept) state_nxt = ST_DECODE;
      ST_DECODE: begin
        if (is_alu_op(opcode))    state_nxt = ST_EXEC;
        else if (opcode == OP_MV) state_nxt = ST_WB;
        else if (opcode == OP_MVI) state_nxt = ST_IMM;
        else                      state_nxt = ST_IDLE;
      end
      ST_IMM:    if (accept) state_nxt = ST_WB;
      ST_EXEC:   state_nxt = ST_WB;
      ST_WB:     state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state      <= ST_IDLE;
      ir         <= '0;
      imm        <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= OP_ADD;
      alu_addsub <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state     <= state_nxt;
      illegal_q <= (state == ST_DECODE) && opcode[3];
      if (state == ST_IDLE && accept) ir <= instr_data[N-1:3];
      if (state == ST_IMM && accept)  imm <= instr_data;
      // Operands are captured in DECODE, so rd may alias rs1/rs2 safely
      if (state == ST_DECODE && is_alu_op(opcode)) begin
        alu_a      <= rs1_data;
        alu_b      <= rs2_data;
        alu_op     <= opcode;
        alu_addsub <= (opcode == OP_SUB);
      end
    end
  end

  // Write-back source is fixed by the instruction class held in IR
  always_comb begin
    wb_data = imm;
    if (is_alu_op(opcode))    wb_data = alu_result;
    else if (opcode == OP_MV) wb_data = rs1_data;
  end

  assign wb_en     = (state == ST_WB);
  assign done      = wb_en;
  assign illegal   = illegal_q;
  assign dbg_state = state;

  regfile8x16 u_regfile (
    .clk   (Clock),
    .rst_n (Resetn),
    .we    (wb_en),
    .wa    (rd),
    .wd    (wb_data),
    .ra1   (rs1),
    .ra2   (rs2),
    .rad   (dbg_sel),
    .rd1   (rs1_data),
    .rd2   (rs2_data),
    .rdd   (dbg_data)
  );

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: behavioural ALU on alu_*/alu_result, a transaction-level
// model of issue timing and register contents, directed scenarios, then random traffic.
module tb_alu_issue_ctrl;
  import alu_issue_ctrl_pkg::*;

  // ---------------- clock / reset ----------------
  logic Clock = 1'b0;
  logic Resetn = 1'b0;
  always #5 Clock = ~Clock;

  logic          instr_valid = 1'b0;
  logic [15:0]   instr_data  = '0;
  logic          instr_ready;
  logic [15:0]   alu_a, alu_b, alu_result, dbg_data;
  logic [3:0]    alu_op;
  logic          alu_addsub, done, illegal;
  logic [2:0]    dbg_sel = '0;
  state_t        dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [15:0] alu_fn(input logic [15:0] a, input logic [15:0] b,
                                         input logic [3:0] op);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_SLT:  return ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
      OP_SLL:  return a << b;
      OP_SLR:  return a >> b;
      OP_AND:  return a & b;
      default: return 16'd0;
    endcase
  endfunction

  assign alu_result = alu_fn(alu_a, alu_b, alu_op);

  alu_issue_ctrl dut (
    .Clock       (Clock),
    .Resetn      (Resetn),
    .instr_valid (instr_valid),
    .instr_data  (instr_data),
    .instr_ready (instr_ready),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_op      (alu_op),
    .alu_addsub  (alu_addsub),
    .alu_result  (alu_result),
    .done        (done),
    .illegal     (illegal),
    .dbg_sel     (dbg_sel),
    .dbg_data    (dbg_data),
    .dbg_state   (dbg_state)
  );

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] mk(input logic [3:0] op, input logic [2:0] rd,
                                     input logic [2:0] rs1, input logic [2:0] rs2);
    return {op, rd, rs1, rs2, 3'b000};
  endfunction

  // ---------------- reference model ----------------
  // Edges are numbered; an accept at edge e schedules its effects at absolute edges.
  logic [15:0] m_reg [8];
  logic [15:0] exp_q [$];     // pending write-back values
  int   ec, ready_from, wr_edge, ill_at, exec_at;
  bit   wr_pend, imm_wait;
  logic [2:0]  wr_rd;
  logic [3:0]  x_op;
  logic [15:0] x_a, x_b;

  always @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      for (int i = 0; i < 8; i++) m_reg[i] = '0;
      exp_q.delete();
      ec = 0; ready_from = 0; wr_edge = -10; ill_at = -10; exec_at = -10;
      wr_pend = 0; imm_wait = 0; wr_rd = '0;
      x_op = '0; x_a = '0; x_b = '0;
    end else begin
      automatic bit rdy = (ec >= ready_from);
      automatic logic [3:0] op = instr_data[15:12];
      automatic logic [2:0] f_rd = instr_data[11:9];
      automatic logic [2:0] f_s1 = instr_data[8:6];
      automatic logic [2:0] f_s2 = instr_data[5:3];
      ec++;
      if (wr_pend && ec == wr_edge) begin
        m_reg[wr_rd] = exp_q.pop_front();
        wr_pend = 0;
      end
      if (instr_valid && rdy) begin
        if (imm_wait) begin
          exp_q.push_back(instr_data);
          wr_pend = 1; wr_edge = ec + 1; ready_from = ec + 1; imm_wait = 0;
        end else if (op <= OP_AND) begin
          x_op = op; x_a = m_reg[f_s1]; x_b = m_reg[f_s2];
          exp_q.push_back(alu_fn(x_a, x_b, op));
          wr_rd = f_rd; wr_pend = 1; wr_edge = ec + 3; ready_from = ec + 3;
          exec_at = ec + 1;
        end else if (op == OP_MV) begin
          exp_q.push_back(m_reg[f_s1]);
          wr_rd = f_rd; wr_pend = 1; wr_edge = ec + 2; ready_from = ec + 2;
        end else if (op == OP_MVI) begin
          wr_rd = f_rd; imm_wait = 1; ready_from = ec + 1;
        end else begin
          ill_at = ec + 1; ready_from = ec + 1;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge Clock) begin
    if (Resetn) begin
      chk("ready", 16'(instr_ready), 16'(ec >= ready_from));
      chk("done", 16'(done), 16'(wr_pend && wr_edge == ec + 1));
      chk("illegal", 16'(illegal), 16'(ec == ill_at));
      chk("dbg_data", dbg_data, m_reg[dbg_sel]);
      if (ec == exec_at) begin
        chk("exec_op", 16'(alu_op), 16'(x_op));
        chk("exec_a", alu_a, x_a);
        chk("exec_b", alu_b, x_b);
        chk("exec_addsub", 16'(alu_addsub), 16'(x_op == OP_SUB));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a negedge; returns just after the negedge following acceptance.
  task automatic send(input logic [15:0] w);
    int n;
    n = 0;
    instr_valid = 1'b1;
    instr_data  = w;
    while (!instr_ready && n < 100) begin
      @(negedge Clock);
      n++;
    end
    if (n >= 100) begin
      n_tests++; n_fail++;
      $display("FAIL send_timeout: word %h not accepted within 100 cycles", w);
      instr_valid = 1'b0;
    end else begin
      @(negedge Clock);
      instr_valid = 1'b0;
      instr_data  = 16'($urandom);
    end
  endtask

  task automatic gap(input int k);
    repeat (k) begin
      #1 dbg_sel = 3'($urandom_range(0, 7));
      @(negedge Clock);
    end
  endtask

  task automatic rd_chk(input string name, input int r, input logic [15:0] e);
    #1 dbg_sel = 3'(r);
    #1 chk(name, dbg_data, e);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  int k;
  logic [3:0] rop;

  initial begin
    repeat (3) @(negedge Clock);
    chk("rst_alu_a", alu_a, 16'h0000);
    chk("rst_alu_b", alu_b, 16'h0000);
    chk("rst_alu_op", 16'(alu_op), 16'h0000);
    chk("rst_addsub", 16'(alu_addsub), 16'h0000);
    chk("rst_done", 16'(done), 16'h0000);
    chk("rst_illegal", 16'(illegal), 16'h0000);
    chk("rst_state", 16'(dbg_state), 16'(ST_IDLE));
    #2 Resetn = 1'b1;
    @(negedge Clock);

    // 1. immediates
    send(mk(OP_MVI, 3'd1, 3'd0, 3'd0)); send(16'h0005);
    send(mk(OP_MVI, 3'd2, 3'd0, 3'd0)); send(16'h0003);
    gap(3);
    rd_chk("mvi_r1", 1, 16'h0005);
    rd_chk("mvi_r2", 2, 16'h0003);
    @(negedge Clock);

    // 2. ADD timing, SUB addsub
    send(mk(OP_ADD, 3'd3, 3'd1, 3'd2));
    chk("add_done_early", 16'(done), 16'h0000);
    @(negedge Clock);
    chk("add_exec_addsub", 16'(alu_addsub), 16'h0000);
    chk("add_done_exec", 16'(done), 16'h0000);
    @(negedge Clock);
    chk("add_done_t3", 16'(done), 16'h0001);
    gap(2);
    send(mk(OP_SUB, 3'd4, 3'd1, 3'd2));
    @(negedge Clock);
    chk("sub_exec_addsub", 16'(alu_addsub), 16'h0001);
    chk("sub_exec_a", alu_a, 16'h0005);
    chk("sub_exec_b", alu_b, 16'h0003);
    gap(3);
    rd_chk("add_r3", 3, 16'h0008);
    rd_chk("sub_r4", 4, 16'h0002);
    @(negedge Clock);

    // 3. SLT / shifts, rd aliasing rs1
    send(mk(OP_SLT, 3'd5, 3'd2, 3'd1)); gap(4);
    rd_chk("slt_r5_a", 5, 16'h0001);
    @(negedge Clock);
    send(mk(OP_SLT, 3'd5, 3'd1, 3'd2)); gap(4);
    rd_chk("slt_r5_b", 5, 16'h0000);
    @(negedge Clock);
    send(mk(OP_SLL, 3'd6, 3'd1, 3'd2)); gap(4);
    rd_chk("sll_r6", 6, 16'h0028);
    @(negedge Clock);
    send(mk(OP_SLR, 3'd6, 3'd6, 3'd2)); gap(4);
    rd_chk("slr_r6", 6, 16'h0005);
    @(negedge Clock);

    // 4. illegal opcode then a normal MV
    send(mk(4'b1010, 3'd1, 3'd2, 3'd3));
    @(negedge Clock);
    chk("ill_pulse", 16'(illegal), 16'h0001);
    chk("ill_no_done", 16'(done), 16'h0000);
    @(negedge Clock);
    chk("ill_pulse_end", 16'(illegal), 16'h0000);
    rd_chk("ill_r1", 1, 16'h0005);
    rd_chk("ill_r2", 2, 16'h0003);
    rd_chk("ill_r3", 3, 16'h0008);
    rd_chk("ill_r4", 4, 16'h0002);
    rd_chk("ill_r5", 5, 16'h0000);
    rd_chk("ill_r6", 6, 16'h0005);
    @(negedge Clock);
    send(mk(OP_MV, 3'd7, 3'd3, 3'd0)); gap(3);
    rd_chk("mv_r7", 7, 16'h0008);
    @(negedge Clock);

    // 5. reset during EXEC
    send(mk(OP_ADD, 3'd7, 3'd1, 3'd2));
    @(negedge Clock);
    #2 Resetn = 1'b0;
    #1;
    chk("abort_alu_a", alu_a, 16'h0000);
    chk("abort_alu_b", alu_b, 16'h0000);
    chk("abort_alu_op", 16'(alu_op), 16'h0000);
    chk("abort_done", 16'(done), 16'h0000);
    chk("abort_state", 16'(dbg_state), 16'(ST_IDLE));
    @(negedge Clock);
    rd_chk("abort_r7", 7, 16'h0000);
    rd_chk("abort_r1", 1, 16'h0000);
    @(negedge Clock);
    #2 Resetn = 1'b1;
    @(negedge Clock);
    chk("abort_ready", 16'(instr_ready), 16'h0001);

    // 6. immediate withheld for 10 cycles
    send(mk(OP_MVI, 3'd0, 3'd0, 3'd0));
    repeat (10) begin
      instr_data = 16'($urandom);
      @(negedge Clock);
    end
    chk("imm_wait_ready", 16'(instr_ready), 16'h0001);
    chk("imm_wait_state", 16'(dbg_state), 16'(ST_IMM));
    send(16'hBEEF);
    gap(2);
    rd_chk("imm_r0", 0, 16'hBEEF);
    @(negedge Clock);

    // random traffic
    for (int i = 0; i < 250; i++) begin
      k = $urandom_range(0, 15);
      rop = (k < 13) ? 4'($urandom_range(0, 7)) : 4'($urandom_range(8, 15));
      send(mk(rop, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
              3'($urandom_range(0, 7))));
      if (rop == OP_MVI) begin
        gap($urandom_range(0, 4));
        send(16'($urandom));
      end
      gap($urandom_range(0, 3));
    end
    gap(6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
